// File: rtl/rsa_modexp_param.sv
// RSA modular exponentiation engine: o_crypto = i_msg^i_key mod i_modulus.
// Bit-serial radix-2 Montgomery datapath with a cached R^2 and tag passthrough.
module rsa_modexp_param #(
   parameter int WIDTH    = 256,
   parameter int TAG_W    = 4,
   parameter int CACHE_R2 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_msg,
   input  logic [WIDTH-1:0] i_key,
   input  logic [WIDTH-1:0] i_modulus,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_crypto,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_r2_hit
);
   localparam int CW = $clog2(2*WIDTH);
   localparam int IW = $clog2(WIDTH);
   localparam int SW = WIDTH + 2;

   typedef enum logic [3:0] {
      S_IDLE, S_R2, S_MIB, S_MIA, S_LMUL,
      S_LSQR, S_MOUT, S_FIN, S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] msg_q, key_q, n_q, base_q, acc_q, r_q;
   logic [TAG_W-1:0] tag_q;
   logic [SW-1:0]    s_q;
   logic [CW-1:0]    cnt_q;
   logic [IW-1:0]    idx_q;
   logic             hit_q;
   logic             cache_vld_q;
   logic [WIDTH-1:0] cache_n_q, cache_r2_q;
   logic [WIDTH-1:0] o_crypto_q;
   logic [TAG_W-1:0] o_tag_q;
   logic             o_r2_hit_q;

   logic             hit, mont_last, r2_last, a_bit;
   logic [WIDTH-1:0] a_src, b_src, mont_res;
   logic [SW-1:0]    s_in, s_nx, s_red;
   logic [SW:0]      t0, t1;
   logic [WIDTH:0]   r_dbl, r_nx;
   logic             unused_ok;

   assign hit = (CACHE_R2 != 0) && cache_vld_q
              && (i_modulus == cache_n_q);
   assign mont_last = (cnt_q == CW'(WIDTH));
   assign r2_last   = (cnt_q == CW'(2*WIDTH-1));

   always_comb begin
      a_src = '0;
      b_src = '0;
      unique case (state_q)
         S_MIB:   begin a_src = msg_q;  b_src = r_q;         end
         S_MIA:   begin a_src = r_q;    b_src = WIDTH'(1);   end
         S_LMUL:  begin a_src = acc_q;  b_src = base_q;      end
         S_LSQR:  begin a_src = base_q; b_src = base_q;      end
         S_MOUT:  begin a_src = acc_q;  b_src = WIDTH'(1);   end
         default: ;
      endcase
   end

   // one Montgomery iteration per cycle; s restarts from 0 on cnt 0
   assign a_bit = a_src[cnt_q[IW-1:0]];
   assign s_in  = (cnt_q == '0) ? '0 : s_q;
   assign t0    = {1'b0, s_in} + ({(SW+1){a_bit}} & {3'b000, b_src});
   assign t1    = t0[0] ? t0 + {3'b000, n_q} : t0;
   assign s_nx  = t1[SW:1];
   assign s_red = (s_q >= {2'b00, n_q}) ? s_q - {2'b00, n_q} : s_q;
   assign mont_res = s_red[WIDTH-1:0];

   assign r_dbl = {r_q, 1'b0};
   assign r_nx  = (r_dbl >= {1'b0, n_q}) ? r_dbl - {1'b0, n_q} : r_dbl;

   assign unused_ok = ^{s_red[SW-1:WIDTH], t1[0], r_nx[WIDTH]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (i_valid) state_d = hit ? S_MIB : S_R2;
         S_R2:   if (r2_last) state_d = S_MIB;
         S_MIB:  if (mont_last) state_d = S_MIA;
         S_MIA:  if (mont_last) state_d = key_q[0] ? S_LMUL : S_LSQR;
         S_LMUL: if (mont_last) state_d = S_LSQR;
         S_LSQR: if (mont_last) begin
            if (idx_q == IW'(WIDTH-1)) state_d = S_MOUT;
            else state_d = key_q[1] ? S_LMUL : S_LSQR;
         end
         S_MOUT: if (mont_last) state_d = S_FIN;
         S_FIN:  state_d = S_DONE;
         S_DONE: if (o_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      i_ready = (state_q == S_IDLE);
      o_valid = (state_q == S_DONE);
   end

   assign o_crypto = o_crypto_q;
   assign o_tag    = o_tag_q;
   assign o_r2_hit = o_r2_hit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msg_q       <= '0;
         key_q       <= '0;
         n_q         <= '0;
         tag_q       <= '0;
         base_q      <= '0;
         acc_q       <= '0;
         r_q         <= '0;
         s_q         <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         hit_q       <= 1'b0;
         cache_vld_q <= 1'b0;
         cache_n_q   <= '0;
         cache_r2_q  <= '0;
         o_crypto_q  <= '0;
         o_tag_q     <= '0;
         o_r2_hit_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (i_valid) begin
               msg_q <= i_msg;
               key_q <= i_key;
               n_q   <= i_modulus;
               tag_q <= i_tag;
               hit_q <= hit;
               cnt_q <= '0;
               idx_q <= '0;
               r_q   <= hit ? cache_r2_q : WIDTH'(1);
            end
            S_R2: begin
               r_q   <= r_nx[WIDTH-1:0];
               cnt_q <= r2_last ? '0 : cnt_q + 1'b1;
               // an even modulus leaves the cache invalid
               if (r2_last) begin
                  cache_vld_q <= n_q[0];
                  cache_n_q   <= n_q;
                  cache_r2_q  <= r_nx[WIDTH-1:0];
               end
            end
            S_MIB, S_MIA, S_LMUL, S_LSQR, S_MOUT: begin
               if (mont_last) begin
                  cnt_q <= '0;
                  if (state_q == S_MIB || state_q == S_LSQR) base_q <= mont_res;
                  else acc_q <= mont_res;
                  if (state_q == S_LSQR) begin
                     key_q <= key_q >> 1;
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  s_q   <= s_nx;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FIN: begin
               o_crypto_q <= acc_q;
               o_tag_q    <= tag_q;
               o_r2_hit_q <= hit_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/rsa_modexp_param.md
Name: rsa_modexp_param

Overview:
- Self-contained, width-parametrised RSA modular exponentiation engine: o_crypto = i_msg^i_key mod i_modulus.
- Integrates one bit-serial radix-2 Montgomery multiplier, the 2^(2W) mod N precompute and the square-and-multiply sequencer behind a single valid/ready request port and a single valid/ready result port.
- Adds two features: a cached R^2 value, so repeated requests with the same modulus skip the precompute, and a request tag carried through to the result.

Parameters:
- WIDTH, 256: key/modulus/message width W in bits, must be at least 4.
- TAG_W, 4: width of the request tag passed through to the result.
- CACHE_R2, 1: when 1, reuse the last 2^(2W) mod N if the modulus is unchanged; when 0, always recompute.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  request valid
- i_ready  out  1  engine idle, request accepted on i_valid&&i_ready
- i_msg  in  WIDTH  message
- i_key  in  WIDTH  exponent
- i_modulus  in  WIDTH  modulus N, must be odd
- i_tag  in  TAG_W  request tag
- o_valid  out  1  result valid
- o_ready  in  1  result accepted on o_valid&&o_ready
- o_crypto  out  WIDTH  result
- o_tag  out  TAG_W  tag of the request that produced o_crypto
- o_r2_hit  out  1  result was computed using the cached R^2

Behaviour:
- Reset values: i_ready=1, o_valid=0, o_crypto=0, o_tag=0, o_r2_hit=0; R^2 cache invalid; state IDLE.
- Request capture: i_ready=1 only in IDLE. On accept, latch msg, key, modulus and tag.
  - Hit = CACHE_R2 && cache valid && i_modulus equals the cached modulus.
  - Next state: MONT_IN on a hit, otherwise R2.
- R2 state: r=1, then exactly 2W cycles, one per cycle, of r=2r; if r>=N then r-=N. Internal r is W+1 bits. On exit, store r and modulus in the cache and set the cache valid.
- Montgomery multiply Mont(a,b) = a*b*2^-W mod N takes M=W+1 cycles:
  - s=0.
  - W iterations, LSB of a first: s+=a_i*b; if s odd then s+=N; s>>=1.
  - Final cycle: if s>=N then s-=N.
  - s is W+2 bits wide.
- MONT_IN: two Montgomery multiplies.
  - base=Mont(msg,R2).
  - acc=Mont(R2,1).
- LOOP: for i=0..W-1 (LSB first):
  - if key[i], acc=Mont(acc,base);
  - then base=Mont(base,base), always performed, including i=W-1.
- MONT_OUT: result=Mont(acc,1).
- DONE: drive o_crypto=result, o_tag, o_r2_hit and o_valid=1.
  - o_crypto, o_tag and o_r2_hit are held stable while o_valid && !o_ready.
  - On o_valid&&o_ready: o_valid=0 next cycle and state=IDLE (i_ready=1 that cycle). No overlap of request and result.
- Latency, from the accept edge to o_valid high: (hit ? 0 : 2W) + M*(3 + W + popcount(key)) + 1 cycles. It is deterministic and independent of o_ready.
- Input ranges:
  - msg>=N is legal; the result is still msg^key mod N.
  - key=0 gives 1 mod N.
  - msg=0 with key>0 gives 0.
  - N=1 gives 0.
- Even modulus: result unspecified, but the handshake completes with the same latency and the engine never hangs. An even-modulus request must not leave the cache valid (cache valid clears in that case).
- Inputs are sampled only on accept; changes to i_* while busy are ignored.
- Reset mid-operation: immediate return to IDLE with all reset values; the cache is invalidated and any in-flight result is lost.
- With CACHE_R2=0: every request runs R2 and o_r2_hit is always 0.

Test Plan:
- WIDTH=16, msg=4, key=13, N=497, tag=3 -> o_crypto=445, o_tag=3, o_r2_hit=0, o_valid exactly 32+17*(3+16+3)+1=407 cycles after accept.
- WIDTH=16, N=3233: encrypt msg=65, key=17, then decrypt msg=2790, key=2753 (tag changes) -> 2790 with r2_hit=0, then 65 with r2_hit=1; the second latency omits the 32 R2 cycles.
- Same modulus after a request with N=497, CACHE_R2=0 -> r2_hit=0 and full latency every time; with CACHE_R2=1 and a different N between requests -> r2_hit=0.
- Edge operands, WIDTH=16, N=3233: key=0 -> 1; msg=0, key=5 -> 0; msg=3300 (>=N), key=1 -> 67; N=1 -> 0.
- Output backpressure: hold o_ready=0 for 50 cycles after o_valid -> o_crypto/o_tag stable, i_ready=0 and new i_valid ignored; release -> i_ready=1 the next cycle.
- Assert rst low mid-LOOP, then resend N=3233 msg=65 key=17 -> reset values immediately, no stale o_valid, r2_hit=0, correct result 2790.
